// File: rtl/alu_pkg.sv
// Shared opcode/state types and sizing helpers for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_OR   = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_MOD  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Iteration counter width; holds WIDTH-1 down to 0.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand-in / result-out handshake bundle for seq_alu.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;
  logic             zero;
  logic             dz_err;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, out, zero, dz_err
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, out, zero, dz_err
  );
endinterface

// File: rtl/alu_mod_iter.sv
// Restoring remainder datapath: first step on start, then WIDTH-1 more,
// with done raised while the counter sits at zero.
module alu_mod_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;

  // One restoring step: shift in a dividend bit, subtract divisor if it fits.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] r,
                                            input logic             nb,
                                            input logic [WIDTH-1:0] d);
    logic [WIDTH:0] t;
    t = {r, nb};
    if (t >= {1'b0, d}) return WIDTH'(t - {1'b0, d});
    else                return t[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      dvd  <= '0;
      dvs  <= '0;
    end else if (start) begin
      rem  <= step('0, a[WIDTH-1], b);
      dvd  <= {a[WIDTH-2:0], 1'b0};
      dvs  <= b;
      cnt  <= CW'(WIDTH - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        rem <= step(rem, dvd[WIDTH-1], dvs);
        dvd <= {dvd[WIDTH-2:0], 1'b0};
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/seq_alu.sv
// Handshaked eight-operation ALU with registered result/flags and an
// iterative modulo path.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);

  localparam int unsigned W1 = WIDTH + 1;

  state_e           state, state_next;
  op_e              op;
  logic             accept, mod_start, load_simple, load_mod, b_zero;
  logic [W1-1:0]    simple_res;
  logic             it_busy, it_done;
  logic [WIDTH-1:0] it_rem;

  assign op        = op_e'(bus.sel);
  assign b_zero    = (bus.b == '0);
  assign accept    = bus.in_valid && bus.in_ready;
  assign mod_start = accept && (op == OP_MOD) && !b_zero;

  alu_mod_iter #(.WIDTH(WIDTH)) u_mod (
    .clk   (clk),
    .rst   (rst),
    .start (mod_start),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (it_busy),
    .done  (it_done),
    .rem   (it_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = mod_start ? BUSY : HOLD;
      end
      BUSY: begin
        if (it_done)      state_next = HOLD;
        else if (!it_busy) state_next = IDLE;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (accept) state_next = mod_start ? BUSY : HOLD;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    load_mod      = 1'b0;
    case (state)
      IDLE: bus.in_ready = 1'b1;
      BUSY: load_mod     = it_done;
      HOLD: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: ;
    endcase
    load_simple = accept && !mod_start;
  end

  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD:  simple_res = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB:  simple_res = {1'b0, bus.a} - {1'b0, bus.b};
      OP_AND:  simple_res = {1'b0, bus.a & bus.b};
      OP_XOR:  simple_res = {1'b0, bus.a ^ bus.b};
      OP_OR:   simple_res = {1'b0, bus.a | bus.b};
      OP_NAND: simple_res = {1'b0, ~(bus.a & bus.b)};
      OP_NOR:  simple_res = {1'b0, ~(bus.a | bus.b)};
      OP_MOD:  simple_res = {1'b0, bus.a};
      default: simple_res = '0;
    endcase
  end

  // Result/flag register; holds while a result waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out    <= '0;
      bus.zero   <= 1'b0;
      bus.dz_err <= 1'b0;
    end else if (load_simple) begin
      bus.out    <= simple_res;
      bus.zero   <= (simple_res == '0);
      bus.dz_err <= (op == OP_MOD);
    end else if (load_mod) begin
      bus.out    <= {1'b0, it_rem};
      bus.zero   <= (it_rem == '0);
      bus.dz_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH = 8.
module tb_seq_alu;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] out;
    logic       zero;
    logic       dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid = v;
    bus.sel      = s;
    bus.a        = av;
    bus.b        = bv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0]  = '{3'b000, 8'd200, 8'd100, 9'h12C, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 8'd5,   8'd9,   9'h1FC, 1'b0, 1'b0};
    vecs[2]  = '{3'b101, 8'hF0,  8'h0F,  9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 8'hCC,  8'hAA,  9'h088, 1'b0, 1'b0};
    vecs[4]  = '{3'b011, 8'h5A,  8'h5A,  9'h000, 1'b1, 1'b0};
    vecs[5]  = '{3'b100, 8'h0C,  8'h30,  9'h03C, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 8'hF0,  8'h0F,  9'h000, 1'b1, 1'b0};
    vecs[7]  = '{3'b111, 8'h33,  8'h00,  9'h033, 1'b0, 1'b1};
    vecs[8]  = '{3'b000, 8'hFF,  8'h01,  9'h100, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 8'h07,  8'h07,  9'h000, 1'b1, 1'b0};
    vecs[10] = '{3'b000, 8'h00,  8'h00,  9'h000, 1'b1, 1'b0};
    vecs[11] = '{3'b111, 8'h00,  8'h00,  9'h000, 1'b1, 1'b1};

    // Reset with a pending operand set that must not be taken.
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b000, 8'h11, 8'h22);
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out",       32'(bus.out),       32'd0);
    check("rst_zero",      32'(bus.zero),      32'd0);
    check("rst_dz",        32'(bus.dz_err),    32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    tick();
    check("rst_no_accept", 32'(bus.out_valid), 32'd0);

    // Back-to-back single-cycle ops and MOD-by-zero, one per cycle.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_out",   i), 32'(bus.out),       32'(vecs[i].out));
      check($sformatf("vec%0d_zero",  i), 32'(bus.zero),      32'(vecs[i].zero));
      check($sformatf("vec%0d_dz",    i), 32'(bus.dz_err),    32'(vecs[i].dz));
    end
    bus.in_valid = 1'b0;
    tick();
    check("drain_idle", 32'(bus.out_valid), 32'd0);

    // Iterative modulo 0xC8 % 0x07: eight BUSY cycles, result in the ninth; operands then change.
    drive(1'b1, 3'b111, 8'hC8, 8'h07);
    tick();
    drive(1'b0, 3'b000, 8'hAB, 8'h01);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) seen++;
      tick();
    end
    check("mod_busy_cycles", 32'(seen), 32'd0);
    check("mod_valid", 32'(bus.out_valid), 32'd1);
    check("mod_out",   32'(bus.out),       32'h004);
    check("mod_zero",  32'(bus.zero),      32'd0);
    check("mod_dz",    32'(bus.dz_err),    32'd0);
    tick();
    check("mod_consumed", 32'(bus.out_valid), 32'd0);

    // Back-pressure on a MOD-by-zero result while the next op waits.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b111, 8'h33, 8'h00);
    tick();
    drive(1'b1, 3'b011, 8'h5A, 8'h5A);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid !== 1'b1 || bus.out !== 9'h033 || bus.zero !== 1'b0 ||
          bus.dz_err !== 1'b1 || bus.in_ready !== 1'b0) seen++;
      tick();
    end
    check("stall_stable", 32'(seen), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("after_stall_out",  32'(bus.out),    32'h000);
    check("after_stall_zero", 32'(bus.zero),   32'd1);
    check("after_stall_dz",   32'(bus.dz_err), 32'd0);
    tick();
    check("after_stall_single", 32'(bus.out_valid), 32'd0);

    // Reset during the 4th BUSY cycle of MOD 0xFF % 0x03.
    drive(1'b1, 3'b111, 8'hFF, 8'h03);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out",      32'(bus.out),      32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
      tick();
    end
    check("midrst_no_output", 32'(seen), 32'd0);

    // Clean MOD after the abort, issued from IDLE.
    drive(1'b1, 3'b111, 8'hFF, 8'h03);
    tick();
    bus.in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && bus.out_valid !== 1'b1; k++) begin
      seen++;
      tick();
    end
    check("remod_latency", 32'(seen), 32'd8);
    check("remod_out",  32'(bus.out),  32'h000);
    check("remod_zero", 32'(bus.zero), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
